// File: rtl/sprite_frame_scheduler.sv
`timescale 1ns/1ps
// Sprite frame scheduler: host writes land in shadow registers and are copied to the
// active sprite registers only at vblank start; also sequences per-sprite animation.
module sprite_frame_scheduler #(
    parameter int NUM_SPRITES  = 8,
    parameter int ANIM_FRAMES  = 3,
    parameter int VACTIVE      = 480,
    parameter int ANIM_DIV_RST = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic                       read,
    input  logic [8:0]                 address,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    input  logic [10:0]                hcount,
    input  logic [9:0]                 vcount,
    output logic [NUM_SPRITES*11-1:0]  sprite_x,
    output logic [NUM_SPRITES*10-1:0]  sprite_y,
    output logic [NUM_SPRITES-1:0]     sprite_en,
    output logic [NUM_SPRITES*2-1:0]   anim_frame,
    output logic                       commit_pulse
);

    localparam logic [8:0] A_EN   = 9'(2 * NUM_SPRITES);
    localparam logic [8:0] A_CTRL = 9'(2 * NUM_SPRITES + 1);
    localparam logic [8:0] A_DIV  = 9'(2 * NUM_SPRITES + 2);
    localparam logic [8:0] A_STAT = 9'(2 * NUM_SPRITES + 3);
    localparam logic [1:0] ANIM_LAST = 2'(ANIM_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                  state_q;
    logic [10:0]             shadow_x_q [NUM_SPRITES];
    logic [9:0]              shadow_y_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]  shadow_en_q;
    logic [10:0]             active_x_q [NUM_SPRITES];
    logic [9:0]              active_y_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]  active_en_q;
    logic [1:0]              anim_q     [NUM_SPRITES];
    logic                    auto_q;
    logic [7:0]              anim_div_q;
    logic [7:0]              anim_cnt_q;
    logic [7:0]              anim_cnt_d;
    logic [15:0]             frame_cnt_q;
    logic [31:0]             rdata_d;

    logic wr_s;
    logic rd_s;
    logic commit_req_s;
    logic div_wr_s;
    logic vblank_start_s;
    logic anim_step_s;
    logic pending_s;

    assign wr_s           = chipselect && write;
    assign rd_s           = chipselect && read;
    assign commit_req_s   = wr_s && (address == A_CTRL) && writedata[0];
    assign div_wr_s       = wr_s && (address == A_DIV);
    assign vblank_start_s = (vcount == 10'(VACTIVE)) && (hcount == 11'd0);
    assign pending_s      = (state_q == S_ARMED);

    // Animation divider: a divider write restarts the count and suppresses that frame's step.
    always_comb begin
        anim_cnt_d  = anim_cnt_q;
        anim_step_s = 1'b0;
        if (div_wr_s) begin
            anim_cnt_d = 8'd0;
        end else if (vblank_start_s && (anim_div_q != 8'd0)) begin
            if (anim_cnt_q == (anim_div_q - 8'd1)) begin
                anim_cnt_d  = 8'd0;
                anim_step_s = 1'b1;
            end else begin
                anim_cnt_d = anim_cnt_q + 8'd1;
            end
        end else begin
            anim_cnt_d = anim_cnt_q;
        end
    end

    // Read mux for the registered Avalon read path.
    always_comb begin
        case (address)
            A_STAT:  rdata_d = {frame_cnt_q, 14'd0, auto_q, pending_s};
            A_DIV:   rdata_d = {24'd0, anim_div_q};
            default: rdata_d = 32'd0;
        endcase
    end

    // Commit sequencer; commit_pulse is high exactly while in COMMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            commit_pulse <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    commit_pulse <= 1'b0;
                    if (commit_req_s || auto_q) begin
                        state_q <= S_ARMED;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (vblank_start_s) begin
                        state_q      <= S_COMMIT;
                        commit_pulse <= 1'b1;
                    end else begin
                        state_q      <= S_ARMED;
                        commit_pulse <= 1'b0;
                    end
                end
                S_COMMIT: begin
                    commit_pulse <= 1'b0;
                    if (auto_q || commit_req_s) begin
                        state_q <= S_ARMED;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    commit_pulse <= 1'b0;
                end
            endcase
        end
    end

    // Shadow registers written by the host.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_x_q[i] <= 11'd0;
                shadow_y_q[i] <= 10'd0;
            end
            shadow_en_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wr_s && (address == 9'(2 * i))) begin
                    shadow_x_q[i] <= writedata[10:0];
                end
                if (wr_s && (address == 9'(2 * i + 1))) begin
                    shadow_y_q[i] <= writedata[9:0];
                end
            end
            if (wr_s && (address == A_EN)) begin
                shadow_en_q <= writedata[NUM_SPRITES-1:0];
            end
        end
    end

    // Active registers; nonblocking copy takes shadow values from before any same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                active_x_q[i] <= 11'd0;
                active_y_q[i] <= 10'd0;
            end
            active_en_q <= '0;
        end else if (state_q == S_COMMIT) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                active_x_q[i] <= shadow_x_q[i];
                active_y_q[i] <= shadow_y_q[i];
            end
            active_en_q <= shadow_en_q;
        end
    end

    // Per-sprite animation index; the enable check sees the pre-commit active value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                anim_q[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (!active_en_q[i]) begin
                    anim_q[i] <= 2'd0;
                end else if (anim_step_s) begin
                    anim_q[i] <= (anim_q[i] == ANIM_LAST) ? 2'd0 : anim_q[i] + 2'd1;
                end
            end
        end
    end

    // Control, counters and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_q      <= 1'b0;
            anim_div_q  <= 8'(ANIM_DIV_RST);
            anim_cnt_q  <= 8'd0;
            frame_cnt_q <= 16'd0;
            readdata    <= 32'd0;
        end else begin
            if (wr_s && (address == A_CTRL)) begin
                auto_q <= writedata[1];
            end
            if (div_wr_s) begin
                anim_div_q <= writedata[7:0];
            end
            anim_cnt_q <= anim_cnt_d;
            if (vblank_start_s) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (rd_s) begin
                readdata <= rdata_d;
            end
        end
    end

    // Flatten per-slot registers onto the packed output buses.
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_out
        assign sprite_x[11*g +: 11]  = active_x_q[g];
        assign sprite_y[10*g +: 10]  = active_y_q[g];
        assign anim_frame[2*g +: 2]  = anim_q[g];
    end
    assign sprite_en = active_en_q;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for sprite_frame_scheduler using a compressed 8x20 video timing
// that still presents vcount 100 and the real vblank line 480.
module tb_sprite_frame_scheduler;

    localparam int N = 8;
    localparam logic [8:0] A_EN   = 9'd16;
    localparam logic [8:0] A_CTRL = 9'd17;
    localparam logic [8:0] A_DIV  = 9'd18;
    localparam logic [8:0] A_STAT = 9'd19;

    logic              clk = 1'b0;
    logic              reset;
    logic              chipselect;
    logic              write;
    logic              read;
    logic [8:0]        address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic [N*11-1:0]   sprite_x;
    logic [N*10-1:0]   sprite_y;
    logic [N-1:0]      sprite_en;
    logic [N*2-1:0]    anim_frame;
    logic              commit_pulse;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;

    int       n_checks = 0;
    int       n_errors = 0;
    int       frame_id = 0;
    int       fr0 = 0;
    rd_exp_t  rd_q[$];
    int       commit_q[$];
    logic     rd_seen = 1'b0;

    always #10 clk = ~clk;

    sprite_frame_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .chipselect   (chipselect),
        .write        (write),
        .read         (read),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .hcount       (hcount),
        .vcount       (vcount),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_en    (sprite_en),
        .anim_frame   (anim_frame),
        .commit_pulse (commit_pulse)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status(input int fc, input logic a, input logic p);
        return {16'(fc), 14'd0, a, p};
    endfunction

    // Video timing: 8 pixels per line; lines 100..104 then 475..489, vblank at 480.
    initial begin
        int ln;
        ln = 0;
        hcount = 11'd0;
        vcount = 10'd100;
        forever begin
            @(posedge clk);
            #1;
            if (hcount == 11'd7) begin
                hcount = 11'd0;
                ln = (ln == 19) ? 0 : ln + 1;
            end else begin
                hcount = hcount + 11'd1;
            end
            vcount = (ln < 5) ? 10'(100 + ln) : 10'(470 + ln);
            if (vcount == 10'd480 && hcount == 11'd0) frame_id++;
        end
    end

    always @(posedge clk) rd_seen <= chipselect && read;

    // Scoreboard: pop expected read data and expected commit frames as the DUT produces them.
    always @(negedge clk) begin
        rd_exp_t e;
        int      ef;
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 128'(rd_q.size()), 128'd1);
            end else begin
                e = rd_q.pop_front();
                check(e.tag, readdata, e.exp);
            end
        end
        if (commit_pulse === 1'b1) begin
            if (commit_q.size() == 0) begin
                check("commit_unexpected", 128'(commit_q.size()), 128'd1);
            end else begin
                ef = commit_q.pop_front();
                check("commit_frame", 128'(frame_id), 128'(ef));
                check("commit_pos", {vcount, hcount}, {10'd480, 11'd1});
            end
        end
    end

    task automatic wr(input logic [8:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #2;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a, input string tag, input logic [31:0] exp);
        rd_exp_t e;
        e.tag = tag;
        e.exp = exp;
        rd_q.push_back(e);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #2;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic wait_line(input logic [9:0] v, input logic [10:0] h);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(vcount == v && hcount == h) && n < 400);
        if (!(vcount == v && hcount == h)) check("wait_line_timeout", {vcount, hcount}, {v, h});
    endtask

    task automatic wait_commit();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (commit_pulse !== 1'b1 && n < 400);
        if (commit_pulse !== 1'b1) check("commit_timeout", 128'(commit_pulse), 128'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, sprite_x, 128'd0);
        check({tag, "_y"}, sprite_y, 128'd0);
        check({tag, "_en"}, sprite_en, 128'd0);
        check({tag, "_anim"}, anim_frame, 128'd0);
        check({tag, "_pulse"}, commit_pulse, 128'd0);
    endtask

    initial begin
        int k;
        int exp_seq [8];
        exp_seq = '{0, 1, 1, 2, 2, 0, 0, 1};
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = 9'd0; writedata = 32'd0;

        // Reset state
        wait_line(10'd100, 11'd0);
        reset = 1'b0;
        fr0 = frame_id;
        @(negedge clk);
        check_all_zero("rst");
        check("rst_readdata", readdata, 128'd0);
        rd(A_STAT, "rst_status", status(0, 1'b0, 1'b0));
        rd(A_DIV, "rst_div", 32'd6);

        // Shadow writes without a commit never reach the outputs
        wr(9'd4, 32'd640);
        wr(9'd5, 32'd300);
        wait_line(10'd100, 11'd0);
        wait_line(10'd100, 11'd0);
        check("t1_x2", sprite_x[22 +: 11], 128'd0);
        check("t1_y2", sprite_y[20 +: 10], 128'd0);
        rd(A_STAT, "t1_status", status(2, 1'b0, 1'b0));

        // Commit request mid-frame, shadow write while armed
        wait_line(10'd100, 11'd0);
        wr(A_CTRL, 32'd1);
        commit_q.push_back(frame_id + 1);
        wr(9'd0, 32'd100);
        rd(A_STAT, "t2_pending", status(frame_id - fr0, 1'b0, 1'b1));
        wait_commit();
        check("t2_x0_lag", sprite_x[0 +: 11], 128'd0);
        @(negedge clk);
        check("t2_x0", sprite_x[0 +: 11], 128'd100);
        check("t2_x2", sprite_x[22 +: 11], 128'd640);
        check("t2_y2", sprite_y[20 +: 10], 128'd300);
        check("t2_pulse_once", commit_pulse, 128'd0);
        rd(A_STAT, "t2_idle", status(frame_id - fr0, 1'b0, 1'b0));

        // Request on the vblank_start cycle lands on the following frame
        wait_line(10'd480, 11'd0);
        wr(A_CTRL, 32'd1);
        commit_q.push_back(frame_id + 1);
        rd(A_STAT, "t3_pending", status(frame_id - fr0, 1'b0, 1'b1));
        wait_commit();
        @(negedge clk);
        check("t3_pulse_once", commit_pulse, 128'd0);

        // Auto mode: one commit per frame, outputs lag shadows by one frame
        wait_line(10'd100, 11'd0);
        k = frame_id;
        wr(A_CTRL, 32'd2);
        wr(9'd3, 32'd200);
        commit_q.push_back(k + 1);
        commit_q.push_back(k + 2);
        commit_q.push_back(k + 3);
        wait_commit();
        check("t4_y1_lag0", sprite_y[10 +: 10], 128'd0);
        @(negedge clk);
        check("t4_y1_200", sprite_y[10 +: 10], 128'd200);
        rd(A_STAT, "t4_auto", status(frame_id - fr0, 1'b1, 1'b1));
        wr(9'd3, 32'd250);
        wait_commit();
        check("t4_y1_lag200", sprite_y[10 +: 10], 128'd200);
        @(negedge clk);
        check("t4_y1_250", sprite_y[10 +: 10], 128'd250);
        wr(A_CTRL, 32'd0);
        wait_commit();
        @(negedge clk);
        rd(A_STAT, "t4_off", status(frame_id - fr0, 1'b0, 1'b0));

        // Animation: divider 2, only slot 0 enabled, then freeze
        wait_line(10'd100, 11'd0);
        wr(A_DIV, 32'd2);
        wr(A_EN, 32'h01);
        wr(A_CTRL, 32'd1);
        commit_q.push_back(frame_id + 1);
        rd(A_DIV, "t5_div", 32'd2);
        for (int j = 0; j < 8; j++) begin
            wait_line(10'd100, 11'd0);
            check($sformatf("t5_anim%0d", j), anim_frame, 128'(exp_seq[j]));
        end
        check("t5_en", sprite_en, 128'h01);
        wr(A_DIV, 32'd0);
        rd(A_DIV, "t5_div0", 32'd0);
        for (int j = 0; j < 3; j++) begin
            wait_line(10'd100, 11'd0);
            check($sformatf("t5_frozen%0d", j), anim_frame, 128'd1);
        end

        // Reset while armed discards the pending commit
        wait_line(10'd100, 11'd0);
        wr(9'd6, 32'd55);
        wr(A_CTRL, 32'd1);
        rd(A_STAT, "t6_armed", status(frame_id - fr0, 1'b0, 1'b1));
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        fr0 = frame_id;
        @(negedge clk);
        check_all_zero("t6_rst");
        rd(A_STAT, "t6_status", status(0, 1'b0, 1'b0));
        rd(A_DIV, "t6_div", 32'd6);
        wait_line(10'd100, 11'd0);
        check("t6_x3", sprite_x[33 +: 11], 128'd0);
        rd(A_STAT, "t6_after", status(1, 1'b0, 1'b0));

        @(negedge clk);
        @(negedge clk);
        check("commit_q_left", 128'(commit_q.size()), 128'd0);
        check("rd_q_left", 128'(rd_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sprite_frame_scheduler.md
Name: sprite_frame_scheduler

Overview:
Frame-synchronous controller for the sprite overlay datapath. Host writes from the Avalon slave land in shadow registers. On request, or every frame in auto mode, a commit copies them into the active registers that drive the sprite compositor, only at the start of vertical blank, so sprites never tear mid-frame. It also sequences per-sprite animation frames (run-cycle / wing-flap selection) on a frame-count basis. It replaces the free-running cycle counter for animation.

Parameters:
NUM_SPRITES, 8, number of sprite slots.
ANIM_FRAMES, 3, animation frames per sprite; anim index wraps modulo this value (2..4).
VACTIVE, 480, first non-active line; vblank starts on this line.
ANIM_DIV_RST, 6, reset value of the animation divider register, in frames.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  9  Avalon word address
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, valid the cycle after read
hcount  in  11  horizontal counter from vga_counters
vcount  in  10  vertical counter from vga_counters
sprite_x  out  NUM_SPRITES*11  active X per sprite; slot i is bits [11i+10:11i]
sprite_y  out  NUM_SPRITES*10  active Y per sprite; slot i is bits [10i+9:10i]
sprite_en  out  NUM_SPRITES  active per-sprite enable
anim_frame  out  NUM_SPRITES*2  per-sprite animation index; slot i is bits [2i+1:2i]
commit_pulse  out  1  high for exactly one cycle when active registers update

Behaviour:
- Reset (synchronous, active-high), applied to state, shadows and outputs:
  - All shadow and active X/Y/enable registers clear to 0; anim_frame clears to 0.
  - commit_pulse=0, readdata=0, state=IDLE, auto=0.
  - anim_div=ANIM_DIV_RST; anim_cnt=0; frame_cnt=0.
  - Reset mid-ARMED discards the pending commit.
- Address map (N=NUM_SPRITES), writes qualified by chipselect&&write:
  - 2i: shadow_x[i] <= writedata[10:0]; 2i+1: shadow_y[i] <= writedata[9:0].
  - 2N: shadow_en <= writedata[N-1:0].
  - 2N+1: control. bit0=1 requests a commit; bit1 sets auto (level, stored).
  - 2N+2: anim_div <= writedata[7:0].
  - Any other address: write ignored.
- Reads, qualified by chipselect&&read, one-cycle latency:
  - 2N+3 (status) returns {frame_cnt[15:0], 14'b0, auto, pending}.
  - 2N+2 returns anim_div zero-extended.
  - Other addresses return 0.
- vblank_start = (vcount==VACTIVE) && (hcount==0): one cycle per frame.
- FSM states:
  - IDLE: a commit request, or auto=1, moves to ARMED. A request in the same cycle as vblank_start still goes to ARMED; that vblank is not used and the commit lands on the next frame.
  - ARMED: pending=1. Shadow writes are still accepted and are included in the commit. On vblank_start go to COMMIT. Repeated requests have no further effect.
  - COMMIT (one cycle):
    - active <= shadow, sampling shadow values from before any write in this same cycle.
    - commit_pulse=1 this cycle; active outputs show new values from the next cycle.
    - Next state is ARMED if auto=1 or a request arrives this cycle; otherwise IDLE.
- Animation, evaluated on vblank_start:
  - frame_cnt increments, 16-bit, wrapping.
  - If anim_div==0, animation is frozen: anim_cnt and anim_frame hold.
  - Else if anim_cnt==anim_div-1: anim_cnt <= 0, and every enabled sprite's anim_frame steps (ANIM_FRAMES-1 wraps to 0).
  - Else anim_cnt increments.
  - Disabled sprites (active sprite_en=0) hold anim_frame at 0.
- A sprite enabled by a commit on the same vblank_start that steps animation keeps 0 for that step, because the enable check uses the pre-commit active value.
- Writing anim_div resets anim_cnt to 0.

Test Plan:
- Reset, then write x[2]=640 (addr 4) and y[2]=300 (addr 5) with no commit over 2 frames -> sprite_x slot 2 stays 0; status pending=0.
- Write ctrl=1 at vcount=100, then x[0]=100 while ARMED -> commit_pulse exactly once, in the cycle after vcount=480/hcount=0; sprite_x slot 0 = 100 from the next cycle; pending back to 0.
- ctrl=1 written exactly on the vblank_start cycle -> no commit that frame; commit on the following frame's vblank_start.
- auto=1 (ctrl=2), then write y[1]=200 and later y[1]=250 in successive frames -> commit_pulse once per frame; sprite_y slot 1 follows 200 then 250 with one-frame lag.
- anim_div=2, enable=0x01 committed -> slot 0 anim_frame steps 0,1,2,0 every 2 frames; slot 1 stays 0; anim_div=0 freezes the sequence.
- Assert reset while ARMED with shadow x[3]=55 -> pending=0, no commit_pulse at next vblank, all outputs 0, anim_div reads back 6.
